// File: rtl/det_scheduler_pkg.sv
// Shared definitions for the detector scheduler slice.
// Holds the per-channel debounce state encoding, the ev_rise codes,
// the width of the debounce counter and a saturating increment helper.
package det_scheduler_pkg;

   typedef enum logic [1:0] {
      QUIET     = 2'd0,
      ARMING    = 2'd1,
      ALARM     = 2'd2,
      RELEASING = 2'd3
   } det_state_t;

   localparam logic EV_FALL = 1'b0;
   localparam logic EV_RISE = 1'b1;

   localparam int CNT_W = 4;

   // The debounce counter sticks at all-ones instead of wrapping, so a
   // threshold can never be hit a second time by overflow.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/det_rr_arbiter.sv
// Round-robin arbiter for the shared detector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request (sample present)
//   gnt        : one-hot grant, combinational, forced to 0 during reset
//   gnt_idx    : index of the granted channel (0 when nothing is granted)
// The rotating pointer marks the channel scanned first; after a grant it
// moves to the channel just past the winner.
module det_rr_arbiter
   import det_scheduler_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req,
   output logic [NCH-1:0] gnt,
   output logic [CW-1:0]  gnt_idx
);

   logic [CW-1:0] ptr;
   logic          found;
   int            scan_idx;

   // Scan ptr, ptr+1, ... modulo NCH and grant the first requester.
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      scan_idx = 0;
      for (int k = 0; k < NCH; k++) begin
         scan_idx = (int'(ptr) + k) % NCH;
         if (!found && rst_n && req[scan_idx]) begin
            gnt[scan_idx] = 1'b1;
            gnt_idx       = CW'(scan_idx);
            found         = 1'b1;
         end
      end
   end

   // Advance past the winner; an idle cycle leaves the pointer alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
      end
   end

endmodule

// File: rtl/det_scheduler.sv
// Time-shares one combinational threshold detector between NCH channels.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   s_valid    : per-channel sample present
//   s_data     : channel i sample at [i*DW +: DW], signed
//   s_ready    : one-hot grant; sample consumed on s_valid & s_ready
//   probe      : registered sample presented to the shared detector
//   detected   : detector verdict for the current probe
//   alarm      : debounced per-channel alarm level
//   ev_valid   : single-cycle strobe for an alarm transition
//   ev_ch      : channel of the transition
//   ev_rise    : 1 = alarm raised, 0 = alarm cleared
// A sample granted at one edge sits on probe for a cycle; its verdict is
// folded into that channel's debounce FSM at the following edge.
module det_scheduler
   import det_scheduler_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DW      = 16,
   parameter int HOLD    = 3,
   parameter int RELEASE = 3,
   parameter int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    s_valid,
   input  logic [NCH*DW-1:0] s_data,
   output logic [NCH-1:0]    s_ready,
   output logic [DW-1:0]     probe,
   input  logic              detected,
   output logic [NCH-1:0]    alarm,
   output logic              ev_valid,
   output logic [CW-1:0]     ev_ch,
   output logic              ev_rise
);

   localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(HOLD);
   localparam logic [CNT_W-1:0] RELEASE_C = CNT_W'(RELEASE);

   logic [NCH-1:0] gnt;
   logic [CW-1:0]  gnt_idx;
   logic           hs;
   logic [CW-1:0]  ch_q;
   logic           pv;
   logic [NCH-1:0] fire;
   logic [NCH-1:0] up;

   det_rr_arbiter #(
      .NCH (NCH),
      .CW  (CW)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (s_valid),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign s_ready = gnt;
   assign hs      = |(s_valid & gnt);

   // Probe stage: capture the granted sample and remember whose it is.
   // probe keeps its last value on idle cycles; pv marks a live verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         probe <= '0;
         ch_q  <= '0;
         pv    <= 1'b0;
      end else if (hs) begin
         probe <= s_data[gnt_idx*DW +: DW];
         ch_q  <= gnt_idx;
         pv    <= 1'b1;
      end else begin
         pv    <= 1'b0;
      end
   end

   // One debounce FSM per channel; only the channel owning the probe
   // sees the verdict, so at most one FSM can fire per cycle.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      det_state_t       state;
      det_state_t       nstate;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] ncnt;
      logic [CNT_W-1:0] cnt_inc;
      logic             sel;

      assign sel     = pv && (ch_q == CW'(i));
      assign cnt_inc = sat_inc(cnt);

      // Hysteresis: HOLD hits in a row raise, RELEASE misses in a row clear.
      always_comb begin
         nstate  = state;
         ncnt    = cnt;
         fire[i] = 1'b0;
         up[i]   = EV_FALL;
         if (sel) begin
            case (state)
               QUIET: begin
                  if (detected) begin
                     if (HOLD_C == CNT_W'(1)) begin
                        nstate  = ALARM;
                        ncnt    = '0;
                        fire[i] = 1'b1;
                        up[i]   = EV_RISE;
                     end else begin
                        nstate = ARMING;
                        ncnt   = CNT_W'(1);
                     end
                  end
               end
               ARMING: begin
                  if (!detected) begin
                     nstate = QUIET;
                     ncnt   = '0;
                  end else if (cnt_inc == HOLD_C) begin
                     nstate  = ALARM;
                     ncnt    = '0;
                     fire[i] = 1'b1;
                     up[i]   = EV_RISE;
                  end else begin
                     ncnt = cnt_inc;
                  end
               end
               ALARM: begin
                  if (!detected) begin
                     if (RELEASE_C == CNT_W'(1)) begin
                        nstate  = QUIET;
                        ncnt    = '0;
                        fire[i] = 1'b1;
                        up[i]   = EV_FALL;
                     end else begin
                        nstate = RELEASING;
                        ncnt   = CNT_W'(1);
                     end
                  end
               end
               RELEASING: begin
                  if (detected) begin
                     nstate = ALARM;
                     ncnt   = '0;
                  end else if (cnt_inc == RELEASE_C) begin
                     nstate  = QUIET;
                     ncnt    = '0;
                     fire[i] = 1'b1;
                     up[i]   = EV_FALL;
                  end else begin
                     ncnt = cnt_inc;
                  end
               end
               default: begin
                  nstate = QUIET;
                  ncnt   = '0;
               end
            endcase
         end
      end

      // Channel state register; untouched unless this channel is selected.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= QUIET;
            cnt   <= '0;
         end else begin
            state <= nstate;
            cnt   <= ncnt;
         end
      end

      assign alarm[i] = (state == ALARM) || (state == RELEASING);
   end

   // Event port: strobe for one cycle, channel and direction held between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_valid <= 1'b0;
         ev_ch    <= '0;
         ev_rise  <= 1'b0;
      end else begin
         ev_valid <= |fire;
         if (|fire) begin
            ev_ch   <= ch_q;
            ev_rise <= |(fire & up);
         end
      end
   end

endmodule
